// File: rtl/aes_round_scheduler.sv
// aes_round_scheduler: round-robin sharing of one iterative AES round
// datapath; emits round control, round index and requester select.
module aes_round_scheduler #(
    parameter int NREQ = 2,
    parameter int SELW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_dec,
    input  logic [2*NREQ-1:0] req_klen,
    output logic [NREQ-1:0]   gnt,
    output logic [SELW-1:0]   sel,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic              busy,
    output logic              rnd_load,
    output logic              rnd_en,
    output logic              rnd_final,
    output logic              rnd_dec,
    output logic [1:0]        rnd_klen,
    output logic [3:0]        rnd_idx,
    output logic [3:0]        rnd_kidx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            dec_q, dec_d;
    logic [1:0]      klen_q, klen_d;
    logic            err_q, err_d;
    logic [3:0]      idx_q, idx_d;
    logic [3:0]      nr;
    logic [SELW-1:0] pick;
    logic            pick_vld;
    logic [1:0]      pick_klen;
    int              scan_j;
    logic            active;

    // Round-robin pick: first requester above the last-served one
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        scan_j   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_j = (int'(ptr_q) + k) % NREQ;
            if (!pick_vld && req[scan_j]) begin
                pick_vld = 1'b1;
                pick     = SELW'(scan_j);
            end
        end
    end

    assign pick_klen = req_klen[2*int'(pick) +: 2];

    // Round count for the latched key length
    always_comb begin
        unique case (klen_q)
            2'b01:   nr = 4'd12;
            2'b10:   nr = 4'd14;
            default: nr = 4'd10;
        endcase
    end

    // State and job registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            ptr_q   <= SELW'(NREQ - 1);
            dec_q   <= 1'b0;
            klen_q  <= 2'b00;
            err_q   <= 1'b0;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            dec_q   <= dec_d;
            klen_q  <= klen_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state and job bookkeeping
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        dec_d   = dec_q;
        klen_d  = klen_q;
        err_d   = err_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    sel_d  = pick;
                    dec_d  = req_dec[pick];
                    klen_d = pick_klen;
                    idx_d  = 4'd0;
                    if (pick_klen == 2'b11) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                idx_d   = 4'd1;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == nr - 4'd1) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                idx_d   = 4'd0;
                state_d = S_DONE;
            end
            S_DONE: begin
                ptr_d   = sel_q;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        active    = (state_q == S_LOAD) ||
                    (state_q == S_ROUND) ||
                    (state_q == S_FINAL);
        busy      = (state_q != S_IDLE);
        rnd_load  = (state_q == S_LOAD);
        rnd_en    = (state_q == S_ROUND) || (state_q == S_FINAL);
        rnd_final = (state_q == S_FINAL);
        rnd_dec   = dec_q;
        rnd_klen  = klen_q;
        sel       = sel_q;
        rnd_idx   = active ? idx_q : 4'd0;
        rnd_kidx  = 4'd0;
        if (active) begin
            rnd_kidx = dec_q ? (nr - idx_q) : idx_q;
        end
        gnt  = '0;
        done = '0;
        if (busy) begin
            gnt[sel_q] = 1'b1;
        end
        if (state_q == S_DONE) begin
            done[sel_q] = 1'b1;
        end
        err = (state_q == S_DONE) && err_q;
    end

endmodule

// File: tb/tb_aes_round_scheduler.sv
// tb_aes_round_scheduler: directed plus randomized stimulus checked
// every cycle against a job-schedule reference model.
module tb_aes_round_scheduler;

    localparam int NREQ = 2;
    localparam int SELW = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_dec;
    logic [2*NREQ-1:0] req_klen;
    logic [NREQ-1:0]   gnt;
    logic [SELW-1:0]   sel;
    logic [NREQ-1:0]   done;
    logic              err;
    logic              busy;
    logic              rnd_load;
    logic              rnd_en;
    logic              rnd_final;
    logic              rnd_dec;
    logic [1:0]        rnd_klen;
    logic [3:0]        rnd_idx;
    logic [3:0]        rnd_kidx;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one job described by owner, Nr and elapsed cycles
    bit       m_act;
    bit       m_ill;
    bit       m_dec;
    int       m_own;
    int       m_sel;
    int       m_ptr;
    int       m_nr;
    int       m_t;
    int       m_klen;
    logic [NREQ-1:0] exp_done;

    aes_round_scheduler #(.NREQ(NREQ)) dut (
        .clk(clk), .reset(reset), .req(req), .req_dec(req_dec),
        .req_klen(req_klen), .gnt(gnt), .sel(sel), .done(done),
        .err(err), .busy(busy), .rnd_load(rnd_load), .rnd_en(rnd_en),
        .rnd_final(rnd_final), .rnd_dec(rnd_dec), .rnd_klen(rnd_klen),
        .rnd_idx(rnd_idx), .rnd_kidx(rnd_kidx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by the edge the DUT is about to take
    task automatic model_edge();
        int last;
        last = m_ill ? 1 : m_nr + 2;
        if (!reset) begin
            m_act = 0; m_ptr = NREQ - 1; m_sel = 0; m_t = 0;
            m_dec = 0; m_klen = 0; m_ill = 0;
        end else if (!m_act) begin
            if (req != 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int j;
                    j = (m_ptr + k) % NREQ;
                    if (!m_act && req[j]) begin
                        m_act  = 1;
                        m_own  = j;
                        m_sel  = j;
                        m_dec  = req_dec[j];
                        m_klen = int'(req_klen[2*j +: 2]);
                        m_ill  = (m_klen == 3);
                        m_nr   = 10 + 2 * m_klen;
                        m_t    = 1;
                    end
                end
            end
        end else if (m_t == last) begin
            m_ptr = m_own; m_act = 0; m_t = 0;
        end else begin
            m_t++;
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] e_gnt;
        bit e_load, e_en, e_fin, e_err;
        int e_idx, e_kidx, last;
        last   = m_ill ? 1 : m_nr + 2;
        e_gnt  = '0;
        exp_done = '0;
        if (m_act) e_gnt[m_own] = 1'b1;
        if (m_act && m_t == last) exp_done[m_own] = 1'b1;
        e_err  = m_act && m_ill && m_t == 1;
        e_load = m_act && !m_ill && m_t == 1;
        e_en   = m_act && !m_ill && m_t >= 2 && m_t <= m_nr + 1;
        e_fin  = m_act && !m_ill && m_t == m_nr + 1;
        e_idx  = (e_load || e_en) ? m_t - 1 : 0;
        e_kidx = (e_load || e_en) ? (m_dec ? m_nr - e_idx : e_idx) : 0;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("sel", 32'(sel), 32'(m_sel));
        chk("done", 32'(done), 32'(exp_done));
        chk("err", 32'(err), 32'(e_err));
        chk("busy", 32'(busy), 32'(m_act));
        chk("rnd_load", 32'(rnd_load), 32'(e_load));
        chk("rnd_en", 32'(rnd_en), 32'(e_en));
        chk("rnd_final", 32'(rnd_final), 32'(e_fin));
        chk("rnd_idx", 32'(rnd_idx), 32'(e_idx));
        chk("rnd_kidx", 32'(rnd_kidx), 32'(e_kidx));
        if (m_act || !reset) begin
            chk("rnd_dec", 32'(rnd_dec), 32'(m_dec));
            chk("rnd_klen", 32'(rnd_klen), 32'(m_klen));
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic run_until_done(input int maxc);
        bit seen;
        seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            cyc();
            seen = (done != 0);
        end
        chk("job_done_seen", 32'(seen), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_act; i++) cyc();
    endtask

    initial begin
        reset = 1'b0; req = '0; req_dec = '0; req_klen = '0;
        m_act = 0; m_ill = 0; m_dec = 0; m_own = 0; m_sel = 0;
        m_ptr = NREQ - 1; m_nr = 10; m_t = 0; m_klen = 0;
        exp_done = '0;
        cyc(); cyc();
        reset = 1'b1;

        // Encrypt AES-128 from requester 0
        req = 2'b01; req_klen = 4'b0000; req_dec = 2'b00;
        run_until_done(20);
        req = 2'b00; drain();

        // Decrypt AES-256 from requester 1
        req = 2'b10; req_klen = 4'b1000; req_dec = 2'b10;
        run_until_done(24);
        req = 2'b00; drain();

        // Both requesting AES-192 continuously
        req = 2'b11; req_klen = 4'b0101; req_dec = 2'b00;
        for (int i = 0; i < 50; i++) cyc();
        req = 2'b00; drain();

        // Illegal key length
        req = 2'b01; req_klen = 4'b0011;
        run_until_done(5);
        req = 2'b00; drain();

        // Drop req and flip direction mid-job
        req = 2'b01; req_klen = 4'b0000; req_dec = 2'b00;
        for (int i = 0; i < 5; i++) cyc();
        req = 2'b00; req_dec = 2'b01;
        run_until_done(20);
        drain();

        // Reset at round index 5, then a lone request from requester 1
        req = 2'b01; req_klen = 4'b0001; req_dec = 2'b00;
        for (int i = 0; i < 20 && !(m_act && m_t == 6); i++) cyc();
        chk("at_idx5", 32'(rnd_idx), 32'd5);
        reset = 1'b0;
        cyc();
        reset = 1'b1; req = 2'b10; req_klen = 4'b0000;
        run_until_done(20);
        req = 2'b00; drain();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                int p;
                if (exp_done[i] && ($urandom % 2 == 0)) req[i] = 1'b0;
                else if (!req[i] && ($urandom % 4 == 0)) req[i] = 1'b1;
                else if (req[i] && ($urandom % 64 == 0)) req[i] = 1'b0;
                if ($urandom % 3 == 0) req_dec[i] = 1'($urandom);
                if ($urandom % 3 == 0) begin
                    p = int'($urandom % 8);
                    req_klen[2*i +: 2] = (p == 7) ? 2'b11 : 2'(p % 3);
                end
            end
            reset = ($urandom % 300 == 0) ? 1'b0 : 1'b1;
            cyc();
        end
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
